// File: rtl/pool_engine.sv
// Streaming max/average pooling engine for square signed images.
// One partial result per output column is kept while the rows of a window stream in.
module pool_engine #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 10,
    parameter int PMAX   = 4
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [LWIDTH-1:0]        img_size,
    input  logic [LWIDTH-1:0]        pool_size,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] pixel_in,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] pixel_out,
    output logic                     busy,
    output logic                     done
);

    localparam int SW    = DWIDTH + 2 * $clog2(PMAX);
    localparam int AW    = LWIDTH - 1;
    localparam int DEPTH = 2 ** LWIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic              mode_q;
    logic [LWIDTH-1:0] img_q;
    logic [1:0]        sh_q;
    logic [LWIDTH-1:0] col_q, row_q;

    logic                     s1_v_q;
    logic                     s1_first_q;
    logic                     s1_last_q;
    logic [AW-1:0]            s1_idx_q;
    logic signed [DWIDTH-1:0] s1_px_q;

    logic                     out_valid_q;
    logic signed [DWIDTH-1:0] pixel_out_q;

    logic [SW-1:0] mem [DEPTH];

    logic              accept;
    logic              end_px;
    logic [LWIDTH-1:0] pmask;
    logic [LWIDTH-1:0] lim;
    logic              in_win;
    logic              win_first;
    logic              win_last;
    logic [AW-1:0]     idx;
    logic [1:0]        sh_new;

    logic signed [SW-1:0]     px_ext;
    logic signed [SW-1:0]     rd;
    logic signed [SW-1:0]     acc;
    logic signed [DWIDTH-1:0] res;

    assign accept = (state_q == S_RUN) && in_valid;
    assign end_px = (col_q == img_q - LWIDTH'(1))
                 && (row_q == img_q - LWIDTH'(1));

    always_comb begin
        sh_new = 2'd0;
        if (pool_size == LWIDTH'(4)) sh_new = 2'd2;
        else if (pool_size == LWIDTH'(2)) sh_new = 2'd1;
    end

    // Window geometry: p is a power of two, so modulo is a mask.
    always_comb begin
        pmask = '0;
        idx   = col_q[LWIDTH-1:1];
        unique case (sh_q)
            2'd2: begin
                pmask = LWIDTH'(3);
                idx   = {1'b0, col_q[LWIDTH-1:2]};
            end
            2'd1: pmask = LWIDTH'(1);
            default: pmask = '0;
        endcase
    end

    assign lim       = img_q & ~pmask;
    assign in_win    = (col_q < lim) && (row_q < lim);
    assign win_first = ((col_q & pmask) == '0) && ((row_q & pmask) == '0);
    assign win_last  = ((col_q & pmask) == pmask)
                    && ((row_q & pmask) == pmask);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (accept && end_px) state_d = S_FLUSH;
            S_FLUSH: if (!s1_v_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            img_q   <= '0;
            sh_q    <= 2'd0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                mode_q <= mode;
                img_q  <= img_size;
                sh_q   <= sh_new;
                col_q  <= '0;
                row_q  <= '0;
            end else if (accept) begin
                if (col_q == img_q - LWIDTH'(1)) begin
                    col_q <= '0;
                    row_q <= row_q + LWIDTH'(1);
                end else begin
                    col_q <= col_q + LWIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= '0;
            s1_px_q    <= '0;
        end else begin
            s1_v_q     <= accept && in_win;
            s1_first_q <= win_first;
            s1_last_q  <= win_last;
            s1_idx_q   <= idx;
            s1_px_q    <= pixel_in;
        end
    end

    assign px_ext = SW'(s1_px_q);
    assign rd     = mem[s1_idx_q];

    always_comb begin
        acc = px_ext;
        if (!s1_first_q) begin
            if (mode_q) acc = rd + px_ext;
            else if (rd > px_ext) acc = rd;
        end
        res = acc[DWIDTH-1:0];
        if (mode_q) res = DWIDTH'(acc >>> {sh_q, 1'b0});
    end

    // Completed windows never need their partial stored back.
    always_ff @(posedge clk) begin
        if (s1_v_q && !s1_last_q) mem[s1_idx_q] <= acc;
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
        end else begin
            out_valid_q <= s1_v_q && s1_last_q;
            if (s1_v_q && s1_last_q) pixel_out_q <= res;
        end
    end

    assign out_valid = out_valid_q;
    assign pixel_out = pixel_out_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pool_engine.sv
// Scoreboard bench for pool_engine: a reference model queues each window
// result as its last pixel is driven; the monitor pops on every out_valid.
module tb_pool_engine;

    localparam int DW = 16;
    localparam int LW = 10;

    logic                 clk = 1'b0;
    logic                 xrst;
    logic                 start;
    logic                 mode;
    logic [LW-1:0]        img_size;
    logic [LW-1:0]        pool_size;
    logic                 in_valid;
    logic signed [DW-1:0] pixel_in;
    logic                 out_valid;
    logic signed [DW-1:0] pixel_out;
    logic                 busy;
    logic                 done;

    pool_engine #(.DWIDTH(DW), .LWIDTH(LW), .PMAX(4)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .start     (start),
        .mode      (mode),
        .img_size  (img_size),
        .pool_size (pool_size),
        .in_valid  (in_valid),
        .pixel_in  (pixel_in),
        .out_valid (out_valid),
        .pixel_out (pixel_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   last_out = -100;
    bit   done_seen = 0;
    bit   chk_done = 0;
    int   pix[64];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            n_out++;
            last_out = cyc;
            if (q.size() == 0) begin
                chk("extra_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("pix_val", pixel_out, e.val);
                chk("pix_lat", cyc, e.cyc);
            end
        end
        if (done) begin
            done_seen = 1;
            chk("busy_at_done", busy, 0);
            if (chk_done) chk("done_lat", cyc, last_out + 1);
        end
    end

    function automatic int exp_win(input bit m, input int img, input int p,
                                   input int r, input int c);
        int s  = 0;
        int mx = -100000;
        for (int dr = 0; dr < p; dr++) begin
            for (int dc = 0; dc < p; dc++) begin
                int v = pix[(r - dr) * img + (c - dc)];
                s += v;
                if (v > mx) mx = v;
            end
        end
        if (m) return s >>> (2 * $clog2(p));
        return mx;
    endfunction

    task automatic fill(input int pat, input int img);
        for (int i = 0; i < img * img; i++) begin
            case (pat)
                0: pix[i] = i;
                1: pix[i] = -3;
                2: pix[i] = (i == 0) ? -1 : -2;
                3: pix[i] = int'($signed(DW'($urandom)));
                default: pix[i] = (i == 3 * img + 3) ? 32767 : -32768;
            endcase
        end
    endtask

    task automatic start_frame(input bit m, input int img, input int p);
        start     = 1'b1;
        mode      = m;
        img_size  = LW'(img);
        pool_size = LW'(p);
        @(posedge clk);
        #1;
        start     = 1'b0;
        mode      = ~m;
        img_size  = '0;
        pool_size = LW'(3);
        chk("busy_run", busy, 1);
        n_out     = 0;
        done_seen = 0;
        chk_done  = (img % p) == 0;
    endtask

    task automatic drive(input bit m, input int img, input int p,
                         input bit gaps, input bit inj, input int npix);
        int lim = img - (img % p);
        for (int i = 0; i < npix; i++) begin
            int r = i / img;
            int c = i % img;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    pixel_in = DW'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            if (inj && i == 3) begin
                in_valid = 1'b0;
                start    = 1'b1;
                @(posedge clk);
                #1;
                start    = 1'b0;
            end
            in_valid = 1'b1;
            pixel_in = DW'(pix[i]);
            if (r < lim && c < lim && (c % p) == p - 1 && (r % p) == p - 1)
                q.push_back('{exp_win(m, img, p, r, c), cyc + 2});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit m, input int img, input int p,
                             input bit gaps, input bit inj);
        start_frame(m, img, p);
        drive(m, img, p, gaps, inj, img * img);
        for (int k = 0; k < 60 && !done_seen; k++) @(posedge clk);
        #1;
        chk("done_seen", done_seen, 1);
        chk("n_out", n_out, (img / p) * (img / p));
        chk("q_empty", q.size(), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        xrst      = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        img_size  = '0;
        pool_size = '0;
        in_valid  = 1'b0;
        pixel_in  = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pixel_out", pixel_out, 0);
        @(posedge clk);
        #1;
        xrst = 1'b0;
        @(posedge clk);
        #1;

        fill(0, 4);
        run_frame(1'b0, 4, 2, 1'b0, 1'b0);
        run_frame(1'b1, 4, 2, 1'b0, 1'b0);
        fill(1, 4);
        run_frame(1'b1, 4, 2, 1'b0, 1'b0);
        fill(2, 4);
        run_frame(1'b1, 4, 2, 1'b0, 1'b0);

        fill(3, 5);
        run_frame(1'b0, 5, 2, 1'b0, 1'b0);
        run_frame(1'b0, 5, 2, 1'b1, 1'b1);

        fill(4, 8);
        run_frame(1'b0, 8, 4, 1'b0, 1'b0);
        fill(3, 8);
        run_frame(1'b1, 8, 4, 1'b1, 1'b0);

        fill(3, 3);
        run_frame(1'b1, 3, 1, 1'b0, 1'b0);
        run_frame(1'b0, 3, 1, 1'b1, 1'b0);

        fill(0, 4);
        start_frame(1'b0, 4, 2);
        drive(1'b0, 4, 2, 1'b0, 1'b0, 7);
        chk("pre_rst_out_valid", out_valid, 1);
        xrst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pixel_out", pixel_out, 0);
        q.delete();
        @(posedge clk);
        #1;
        xrst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(1'b0, 4, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
